hazard_detect: RTL

HAZARD_DETECT -- requirements
Module: hazard_detect

---
 rtl/hazard_detect_pkg.sv | 29 ++
 rtl/hazard_match.sv | 61 ++++++
 rtl/hazard_detect.sv | 111 +++++++++++
 3 files changed

// File: rtl/hazard_detect_pkg.sv
// Shared definitions for the decode-stage hazard detector.
//   hist_entry_t : one in-flight producer record {valid, rd, reg_write, is_load, is_lui}
//   state_t      : load-use FSM states (RUN / STALL)
//   writes_reg() : true when a history entry is a live producer for a used source register
package hazard_detect_pkg;

  localparam int REG_W          = 5;
  localparam int HIST_DEPTH_DEF = 3;
  localparam int CNT_W          = 16;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             is_load;
    logic             is_lui;
  } hist_entry_t;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } state_t;

  // x0 is hardwired zero, so a producer of x0 never creates a dependency.
  function automatic logic writes_reg(hist_entry_t e, logic [REG_W-1:0] rs, logic use_rs);
    return e.valid && e.reg_write && (e.rd != '0) && use_rs && (e.rd == rs);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-operand slot-priority matcher.
//   hist     : producer history, index 0 = slot 1 (one stage ahead of decode)
//   rs/use_rs: decode source register and whether it is read
//   load_use : youngest producer is a load in slot 1 (needs a bubble)
//   alu1/alu2/rf : forward from slot 1 / slot 2 / slot 3+ (one-hot or zero)
//   lui1/lui2: the selected slot-1 / slot-2 producer is a LUI
// HIST_DEPTH must be at least 3.
module hazard_match
  import hazard_detect_pkg::*;
#(
  parameter int HIST_DEPTH = HIST_DEPTH_DEF
) (
  input  hist_entry_t [HIST_DEPTH-1:0] hist,
  input  logic [REG_W-1:0]             rs,
  input  logic                         use_rs,
  output logic                         load_use,
  output logic                         alu1,
  output logic                         alu2,
  output logic                         rf,
  output logic                         lui1,
  output logic                         lui2
);

  logic [HIST_DEPTH-1:0] hit;
  logic                  older_hit;
  logic                  unused_fields;

  always_comb begin
    for (int k = 0; k < HIST_DEPTH; k++) hit[k] = writes_reg(hist[k], rs, use_rs);
  end

  always_comb begin
    load_use  = 1'b0;
    alu1      = 1'b0;
    alu2      = 1'b0;
    rf        = 1'b0;
    lui1      = 1'b0;
    lui2      = 1'b0;
    older_hit = 1'b0;
    for (int k = 2; k < HIST_DEPTH; k++) older_hit = older_hit | hit[k];
    // Youngest producer wins; a slot-1 load blocks older forwards for this operand.
    if (hit[0]) begin
      load_use = hist[0].is_load;
      alu1     = !hist[0].is_load;
      lui1     = !hist[0].is_load && hist[0].is_lui;
    end else if (hit[1]) begin
      alu2 = 1'b1;
      lui2 = hist[1].is_lui;
    end else if (older_hit) begin
      rf = 1'b1;
    end
  end

  // Load/LUI flags of older slots do not affect the select.
  always_comb begin
    unused_fields = hist[1].is_load;
    for (int k = 2; k < HIST_DEPTH; k++)
      unused_fields = unused_fields ^ hist[k].is_load ^ hist[k].is_lui;
  end

endmodule

// File: rtl/hazard_detect.sv
// Decode-stage data hazard detector: forwarding selects plus load-use stall.
//   clk, rst              : clock, async active-high reset
//   rs1, rs2, rd          : decode register indices
//   idValid, regWrite, isLoad, isLui, useRs1, useRs2 : decode qualifiers
//   ALU1xhz/ALU2xhz/Rxhz  : forward operand x from slot 1 / slot 2 / slot 3
//   luiHaz1, luiHaz2      : the slot-1 / slot-2 forward source is a LUI
//   nop, stall            : one-cycle bubble + decode hold on load-use
//   stallCnt              : saturating load-use stall counter
module hazard_detect
  import hazard_detect_pkg::*;
#(
  parameter int HIST_DEPTH = HIST_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  input  logic             idValid,
  input  logic             regWrite,
  input  logic             isLoad,
  input  logic             isLui,
  input  logic             useRs1,
  input  logic             useRs2,
  output logic             ALU1Ahz,
  output logic             ALU1Bhz,
  output logic             ALU2Ahz,
  output logic             ALU2Bhz,
  output logic             RAhz,
  output logic             RBhz,
  output logic             luiHaz1,
  output logic             luiHaz2,
  output logic             nop,
  output logic             stall,
  output logic [CNT_W-1:0] stallCnt
);

  hist_entry_t [HIST_DEPTH-1:0] hist_q, hist_d;
  state_t                       state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  logic [1:0][REG_W-1:0] op_rs;
  logic [1:0]            op_use;
  logic [1:0]            lu, alu1, alu2, rf, lui1, lui2;
  logic                  load_use;
  logic                  sel_en;

  assign op_rs  = {rs2, rs1};
  assign op_use = {useRs2, useRs1};

  // Operand 0 = A (rs1), operand 1 = B (rs2).
  for (genvar g = 0; g < 2; g++) begin : gen_op
    hazard_match #(.HIST_DEPTH(HIST_DEPTH)) u_match (
      .hist     (hist_q),
      .rs       (op_rs[g]),
      .use_rs   (op_use[g]),
      .load_use (lu[g]),
      .alu1     (alu1[g]),
      .alu2     (alu2[g]),
      .rf       (rf[g]),
      .lui1     (lui1[g]),
      .lui2     (lui2[g])
    );
  end

  always_comb begin
    // In STALL the load already sits in slot 2, so it cannot re-trigger.
    load_use = (state_q == ST_RUN) && (|lu);

    state_d = state_q;
    case (state_q)
      ST_RUN:   if (load_use) state_d = ST_STALL;
      ST_STALL: state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase

    hist_d[0] = '0;
    if (idValid && !load_use) hist_d[0] = {1'b1, rd, regWrite, isLoad, isLui};
    for (int k = 1; k < HIST_DEPTH; k++) hist_d[k] = hist_q[k-1];

    cnt_d = cnt_q;
    if (load_use && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      hist_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hist_q  <= hist_d;
      cnt_q   <= cnt_d;
    end
  end

  // The bubble cycle forwards nothing; reset silences every output at once.
  assign sel_en   = !rst && !load_use;
  assign ALU1Ahz  = sel_en & alu1[0];
  assign ALU1Bhz  = sel_en & alu1[1];
  assign ALU2Ahz  = sel_en & alu2[0];
  assign ALU2Bhz  = sel_en & alu2[1];
  assign RAhz     = sel_en & rf[0];
  assign RBhz     = sel_en & rf[1];
  assign luiHaz1  = sel_en & (|lui1);
  assign luiHaz2  = sel_en & (|lui2);
  assign nop      = !rst & load_use;
  assign stall    = !rst & load_use;
  assign stallCnt = rst ? '0 : cnt_q;

endmodule
